// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply accelerator register interface.
package matmul_pkg;

  localparam int MAX_DIM       = 8;
  localparam int CONTROL_WIDTH = 16;

  // Register regions selected by paddr[4:0]
  typedef enum logic [4:0] {
    REG_CONTROL   = 5'h00,
    REG_OPERAND_A = 5'h04,
    REG_FLAGS     = 5'h08,
    REG_OPERAND_B = 5'h0C,
    REG_SP        = 5'h10
  } region_e;

  // APB completer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Region decode and access-error check for the APB completer.
module apb_addr_decode
  import matmul_pkg::*;
(
  input  logic [4:0] i_region,
  input  logic       i_write,
  input  logic       i_busy,
  output logic       o_err
);

  logic w_mapped;
  logic w_writable;

  // Classify the region; only CONTROL and the operands accept writes
  always_comb begin
    w_mapped   = 1'b0;
    w_writable = 1'b0;
    case (i_region)
      REG_CONTROL, REG_OPERAND_A, REG_OPERAND_B: begin
        w_mapped   = 1'b1;
        w_writable = 1'b1;
      end
      REG_FLAGS, REG_SP: w_mapped = 1'b1;
      default: ;
    endcase
  end

  // Writes to writable regions are refused while the engine is running
  always_comb begin
    o_err = ~w_mapped | (i_write & (~w_writable | i_busy));
  end

endmodule

// File: rtl/apb_slave_module.sv
// APB completer bridging the bus onto the register file interface.
// state     | meaning
// ST_IDLE   | waiting for a setup phase (psel=1, penable=0)
// ST_ACCESS | request latched; writes complete here, reads capture rf data
// ST_RDATA  | read wait state; captured data returned with pready
module apb_slave_module
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [ADDR_WIDTH-1:0]  paddr_i,
  input  logic [BUS_WIDTH-1:0]   pwdata_i,
  input  logic [BUS_WIDTH/8-1:0] pstrb_i,
  output logic                   pready_o,
  output logic [BUS_WIDTH-1:0]   prdata_o,
  output logic                   pslverr_o,
  input  logic                   busy_i,
  input  logic [BUS_WIDTH-1:0]   rf_data_i,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic [BUS_WIDTH-1:0]   data_o,
  output logic [BUS_WIDTH/8-1:0] strobe_o,
  output logic                   write_enable_o
);

  // A bus narrower than one matrix element cannot carry operands
  if (BUS_WIDTH < DATA_WIDTH) begin : g_width_check
    $error("BUS_WIDTH must be at least DATA_WIDTH");
  end

  apb_state_e             r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [BUS_WIDTH-1:0]   r_data;
  logic [BUS_WIDTH/8-1:0] r_strb;
  logic                   r_write;
  logic                   r_err;
  logic [BUS_WIDTH-1:0]   r_prdata;

  logic w_setup;
  logic w_sel_en;
  logic w_err;
  logic w_pready;

  assign w_setup  = psel_i & ~penable_i;
  assign w_sel_en = psel_i & penable_i;

  apb_addr_decode u_decode (
    .i_region (paddr_i[4:0]),
    .i_write  (pwrite_i),
    .i_busy   (busy_i),
    .o_err    (w_err)
  );

  // Handshake FSM; request fields are latched at setup so busy changes later are ignored
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_strb   <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_prdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_addr  <= paddr_i;
            r_data  <= pwdata_i;
            r_strb  <= pstrb_i;
            r_write <= pwrite_i;
            r_err   <= w_err;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!w_sel_en) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_strb   <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_prdata <= '0;
            r_state  <= ST_IDLE;
          end else if (r_write) begin
            r_state <= ST_IDLE;
          end else begin
            r_prdata <= r_err ? '0 : rf_data_i;
            r_state  <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (!w_sel_en) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_strb   <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_prdata <= '0;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Completion is combinational so writes finish with zero wait states
  always_comb begin
    w_pready = w_sel_en & (((r_state == ST_ACCESS) & r_write) | (r_state == ST_RDATA));
  end

  assign pready_o       = w_pready;
  assign pslverr_o      = w_pready & r_err;
  assign write_enable_o = w_sel_en & (r_state == ST_ACCESS) & r_write & ~r_err;
  assign prdata_o       = r_prdata;
  assign address_o      = r_addr;
  assign data_o         = r_data;
  assign strobe_o       = r_strb;

endmodule

// File: tb/tb_apb_slave_module.sv
// Self-checking bench for apb_slave_module with a behavioural access model.
module tb_apb_slave_module;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i;
  logic [63:0] pwdata_i;
  logic [7:0]  pstrb_i;
  logic        pready_o;
  logic [63:0] prdata_o;
  logic        pslverr_o;
  logic        busy_i;
  logic [63:0] rf_data_i;
  logic [31:0] address_o;
  logic [63:0] data_o;
  logic [7:0]  strobe_o;
  logic        write_enable_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_prdata;
  bit          prdata_known;

  apb_slave_module #(.DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .busy_i(busy_i), .rf_data_i(rf_data_i), .address_o(address_o),
    .data_o(data_o), .strobe_o(strobe_o), .write_enable_o(write_enable_o)
  );

  always #5 clk_i = ~clk_i;

  // Error rule: unmapped, or write to a read-only region, or write while busy
  function automatic bit exp_err(input logic [4:0] r, input bit wr, input bit b);
    bit mapped = (r inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10});
    bit ro     = (r inside {5'h08, 5'h10});
    return !mapped || (wr && (ro || b));
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic b, input logic b_acc);
    bit e = exp_err(a[4:0], 1'b1, b);
    @(posedge clk_i); #1;
    psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = a; pwdata_i = d; pstrb_i = s; busy_i = b;
    @(negedge clk_i);
    n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL wr_setup_pready got %b exp 0", pready_o); end
    n_checks++; if (write_enable_o !== 1'b0) begin n_errors++; $display("FAIL wr_setup_we got %b exp 0", write_enable_o); end
    @(posedge clk_i); #1;
    penable_i = 1; busy_i = b_acc; paddr_i = ~a; pwdata_i = ~d; pstrb_i = ~s;
    @(negedge clk_i);
    n_checks++; if (pready_o !== 1'b1) begin n_errors++; $display("FAIL wr_pready got %b exp 1", pready_o); end
    n_checks++; if (pslverr_o !== e) begin n_errors++; $display("FAIL wr_pslverr a=%h got %b exp %b", a, pslverr_o, e); end
    n_checks++; if (write_enable_o !== !e) begin n_errors++; $display("FAIL wr_we a=%h got %b exp %b", a, write_enable_o, !e); end
    n_checks++; if (address_o !== a) begin n_errors++; $display("FAIL wr_addr got %h exp %h", address_o, a); end
    n_checks++; if (data_o !== d) begin n_errors++; $display("FAIL wr_data got %h exp %h", data_o, d); end
    n_checks++; if (strobe_o !== s) begin n_errors++; $display("FAIL wr_strb got %h exp %h", strobe_o, s); end
  endtask

  task automatic do_read(input logic [31:0] a, input logic b, input logic [63:0] rd);
    bit e = exp_err(a[4:0], 1'b0, b);
    @(posedge clk_i); #1;
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = a; pwdata_i = {$urandom, $urandom}; busy_i = b;
    @(negedge clk_i);
    n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL rd_setup_pready got %b exp 0", pready_o); end
    n_checks++; if (write_enable_o !== 1'b0) begin n_errors++; $display("FAIL rd_setup_we got %b exp 0", write_enable_o); end
    @(posedge clk_i); #1;
    penable_i = 1; busy_i = ~b; rf_data_i = rd;
    @(negedge clk_i);
    n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL rd_access_pready got %b exp 0", pready_o); end
    n_checks++; if (write_enable_o !== 1'b0) begin n_errors++; $display("FAIL rd_access_we got %b exp 0", write_enable_o); end
    n_checks++; if (address_o !== a) begin n_errors++; $display("FAIL rd_addr got %h exp %h", address_o, a); end
    @(posedge clk_i); #1;
    rf_data_i = ~rd;
    exp_prdata = e ? 64'd0 : rd;
    prdata_known = 1;
    @(negedge clk_i);
    n_checks++; if (pready_o !== 1'b1) begin n_errors++; $display("FAIL rd_pready got %b exp 1", pready_o); end
    n_checks++; if (pslverr_o !== e) begin n_errors++; $display("FAIL rd_pslverr a=%h got %b exp %b", a, pslverr_o, e); end
    n_checks++; if (prdata_o !== exp_prdata) begin n_errors++; $display("FAIL rd_prdata got %h exp %h", prdata_o, exp_prdata); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      psel_i = 0; penable_i = 0;
      @(negedge clk_i);
      n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL idle_pready got %b exp 0", pready_o); end
      n_checks++; if (write_enable_o !== 1'b0) begin n_errors++; $display("FAIL idle_we got %b exp 0", write_enable_o); end
      if (prdata_known) begin
        n_checks++; if (prdata_o !== exp_prdata) begin n_errors++; $display("FAIL idle_prdata_hold got %h exp %h", prdata_o, exp_prdata); end
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1; psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = '0; pwdata_i = '0;
    pstrb_i = '0; busy_i = 0; rf_data_i = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({pready_o, pslverr_o, write_enable_o} !== 3'b000 || prdata_o !== '0 ||
        address_o !== '0 || data_o !== '0 || strobe_o !== '0) begin
      n_errors++; $display("FAIL reset_outputs got rdy=%b err=%b we=%b rd=%h a=%h d=%h s=%h exp all 0",
                           pready_o, pslverr_o, write_enable_o, prdata_o, address_o, data_o, strobe_o);
    end
    @(posedge clk_i); #1; rst_i = 0;
    exp_prdata = 0; prdata_known = 1;
  endtask

  task automatic test_directed;
    do_write(32'h04, 64'h0000_0002_0000_0001, 8'hFF, 0, 0);
    idle(1);
    do_read(32'h00, 0, 64'h1234);
    idle(2);
    do_write(32'h08, 64'h55, 8'hFF, 0, 0);
    idle(1);
    do_write(32'h00, 64'h1, 8'h03, 1, 1);
    idle(1);
    do_read(32'h00, 1, 64'h0000_0000_0000_0001);
    idle(1);
    do_read(32'h14, 0, 64'hFFFF_0000_AAAA_5555);
    idle(1);
    do_write(32'h0C, 64'h77, 8'h0F, 1, 0);
    idle(1);
    do_write(32'h0C, 64'h78, 8'hF0, 0, 1);
    idle(1);
  endtask

  task automatic test_back_to_back;
    do_write(32'h1000_0004, 64'hA5A5_0000_0000_5A5A, 8'h33, 0, 0);
    do_read(32'h2000_000C, 0, 64'h0123_4567_89AB_CDEF);
    do_write(32'h10, 64'h9, 8'hFF, 0, 0);
    do_read(32'h08, 1, 64'h0F0F);
    idle(2);
  endtask

  task automatic test_penable_only;
    @(posedge clk_i); #1; psel_i = 1; penable_i = 1; pwrite_i = 1; paddr_i = 32'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_checks++; if (pready_o !== 1'b0 || write_enable_o !== 1'b0) begin
        n_errors++; $display("FAIL penable_only got rdy=%b we=%b exp 0 0", pready_o, write_enable_o);
      end
    end
    idle(1);
  endtask

  task automatic test_abort;
    @(posedge clk_i); #1; psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 32'h04;
    @(posedge clk_i); #1; psel_i = 0; penable_i = 1; rf_data_i = 64'h1111;
    prdata_known = 0;
    @(negedge clk_i);
    n_checks++; if (pready_o !== 1'b0) begin n_errors++; $display("FAIL abort_access_pready got %b exp 0", pready_o); end
    @(posedge clk_i); #1; penable_i = 0;
    @(negedge clk_i);
    n_checks++; if (address_o !== '0) begin n_errors++; $display("FAIL abort_cleared_addr got %h exp 0", address_o); end
    idle(3);
    do_read(32'h0C, 0, 64'h2222_3333);
    idle(1);
  endtask

  task automatic test_reset_mid_write;
    @(posedge clk_i); #1; psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 32'h04;
    pwdata_i = 64'h42; pstrb_i = 8'hFF; busy_i = 0;
    @(posedge clk_i); #1; penable_i = 1;
    @(negedge clk_i);
    n_checks++; if (write_enable_o !== 1'b1) begin n_errors++; $display("FAIL rst_pre_we got %b exp 1", write_enable_o); end
    #1 rst_i = 1;
    #1;
    n_checks++;
    if ({pready_o, pslverr_o, write_enable_o} !== 3'b000 || prdata_o !== '0 ||
        address_o !== '0 || data_o !== '0 || strobe_o !== '0) begin
      n_errors++; $display("FAIL rst_mid_write got rdy=%b err=%b we=%b a=%h d=%h exp all 0",
                           pready_o, pslverr_o, write_enable_o, address_o, data_o);
    end
    @(posedge clk_i); #1; rst_i = 0; psel_i = 0; penable_i = 0;
    exp_prdata = 0; prdata_known = 1;
    idle(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int k = $urandom_range(0, 7);
      a = {$urandom} & 32'hFFFF_FFE0;
      case (k)
        0: a[4:0] = 5'h00;
        1: a[4:0] = 5'h04;
        2: a[4:0] = 5'h08;
        3: a[4:0] = 5'h0C;
        4: a[4:0] = 5'h10;
        default: a[4:0] = 5'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(a, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom));
      else
        do_read(a, 1'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_penable_only;
    test_abort;
    test_reset_mid_write;
    test_random;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
